// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (IF) and load/store (LS).
// Optional watchdog on the WAIT state is built when MEM_ARB_TIMEOUT_EN is defined.
module mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  output logic        if_resp_valid,
  output logic [31:0] if_rdata,
  output logic        if_resp_err,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic [31:0] ls_addr,
  input  logic        ls_wen,
  input  logic [3:0]  ls_wmask,
  input  logic [31:0] ls_wdata,
  output logic        ls_resp_valid,
  output logic [31:0] ls_rdata,
  output logic        ls_resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        timeout_flag
);
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      r_state, w_next;
  logic        r_last_ls, r_owner_ls;
  logic        r_if_rvalid, r_ls_rvalid;
  logic [31:0] r_if_rdata, r_ls_rdata;
  logic [31:0] r_addr, r_wdata;
  logic        r_wen;
  logic [3:0]  r_wmask;
  logic        w_grant_if, w_accept, w_done, w_tout;

  // On a tie the side that did not win last time gets the port.
  assign w_grant_if = if_req_valid && (!ls_req_valid || r_last_ls);
  assign w_accept   = (r_state == S_IDLE) && (if_req_valid || ls_req_valid);
  assign w_done     = ((r_state == S_REQ) && mem_req_ready && mem_resp_valid) ||
                      ((r_state == S_WAIT) && mem_resp_valid);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          r_tflag, r_if_err, r_ls_err;

  // A real response in the limit cycle takes priority over the timeout.
  assign w_tout = (r_state == S_WAIT) && !mem_resp_valid && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_tflag  <= 1'b0;
      r_if_err <= 1'b0;
      r_ls_err <= 1'b0;
    end else begin
      r_cnt    <= (r_state == S_WAIT) ? r_cnt + 1'b1 : '0;
      r_tflag  <= r_tflag | w_tout;
      r_if_err <= w_tout && !r_owner_ls;
      r_ls_err <= w_tout && r_owner_ls;
    end
  end

  assign timeout_flag = r_tflag;
  assign if_resp_err  = r_if_err;
  assign ls_resp_err  = r_ls_err;
`else
  assign w_tout       = 1'b0;
  assign timeout_flag = 1'b0;
  assign if_resp_err  = 1'b0;
  assign ls_resp_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_REQ;
      S_REQ:   if (mem_req_ready) w_next = mem_resp_valid ? S_IDLE : S_WAIT;
      S_WAIT:  if (mem_resp_valid || w_tout) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    if_req_ready  = (r_state == S_IDLE) && w_grant_if;
    ls_req_ready  = (r_state == S_IDLE) && !w_grant_if && ls_req_valid;
    mem_req_valid = (r_state == S_REQ);
    busy          = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_ls  <= 1'b1;
      r_owner_ls <= 1'b0;
      r_addr     <= '0;
      r_wen      <= 1'b0;
      r_wmask    <= '0;
      r_wdata    <= '0;
    end else if (w_accept) begin
      r_last_ls  <= !w_grant_if;
      r_owner_ls <= !w_grant_if;
      r_addr     <= w_grant_if ? if_addr : ls_addr;
      r_wen      <= !w_grant_if && ls_wen;
      r_wmask    <= w_grant_if ? 4'h0 : ls_wmask;
      r_wdata    <= w_grant_if ? 32'h0 : ls_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rdata  <= '0;
    end else begin
      r_if_rvalid <= (w_done || w_tout) && !r_owner_ls;
      r_ls_rvalid <= (w_done || w_tout) && r_owner_ls;
      if (w_done || w_tout) begin
        if (r_owner_ls) r_ls_rdata <= w_done ? mem_rdata : 32'h0;
        else            r_if_rdata <= w_done ? mem_rdata : 32'h0;
      end
    end
  end

  assign mem_addr      = r_addr;
  assign mem_wen       = r_wen;
  assign mem_wmask     = r_wmask;
  assign mem_wdata     = r_wdata;
  assign if_resp_valid = r_if_rvalid;
  assign ls_resp_valid = r_ls_rvalid;
  assign if_rdata      = r_if_rdata;
  assign ls_rdata      = r_ls_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model of grants and responses.
module tb_mem_arbiter;
  logic        clk = 1'b0, rst;
  logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_err;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid, ls_resp_err;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [3:0]  ls_wmask, mem_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, busy, timeout_flag;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata), .if_resp_err(if_resp_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wmask(ls_wmask), .ls_wdata(ls_wdata),
    .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata), .ls_resp_err(ls_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .busy(busy), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  int          n_tests = 0, n_fail = 0;
  bit          m_last_ls, p_if, p_ls, own_ls;
  logic [31:0] m_if_rd, m_ls_rd, e_addr, e_wdata, x_rd;
  logic        e_wen;
  logic [3:0]  e_wmask;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic req_if(input logic [31:0] a);
    if_addr = a; if_req_valid = 1'b1; p_if = 1'b1;
  endtask

  task automatic req_ls(input logic [31:0] a, input logic w, input logic [3:0] m, input logic [31:0] d);
    ls_addr = a; ls_wen = w; ls_wmask = m; ls_wdata = d; ls_req_valid = 1'b1; p_ls = 1'b1;
  endtask

  task automatic rand_reqs(input bit w_if, input bit w_ls);
    if (w_if && !p_if) req_if($urandom);
    if (w_ls && !p_ls) req_ls($urandom, 1'($urandom), 4'($urandom), $urandom);
  endtask

  task automatic model_reset();
    if_req_valid = 0; ls_req_valid = 0; p_if = 0; p_ls = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
    m_last_ls = 1'b1; m_if_rd = 0; m_ls_rd = 0;
  endtask

  task automatic check_reset_state();
    chk("rst_busy", busy, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_resp_valid", {if_resp_valid, ls_resp_valid}, 0);
    chk("rst_resp_err", {if_resp_err, ls_resp_err}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    chk("rst_timeout_flag", timeout_flag, 0);
  endtask

  task automatic do_reset();
    model_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_reset_state();
  endtask

  // Called at a negedge with the arbiter idle and requests already driven.
  task automatic accept();
    #1;
    own_ls = (p_if && p_ls) ? !m_last_ls : p_ls;
    chk("if_req_ready", if_req_ready, !own_ls);
    chk("ls_req_ready", ls_req_ready, own_ls);
    if (own_ls) begin
      e_addr = ls_addr; e_wen = ls_wen; e_wmask = ls_wmask; e_wdata = ls_wdata;
    end else begin
      e_addr = if_addr; e_wen = 0; e_wmask = 0; e_wdata = 0;
    end
    step();
    if (own_ls) begin
      ls_req_valid = 0; p_ls = 0; ls_addr = $urandom; ls_wdata = $urandom;
    end else begin
      if_req_valid = 0; p_if = 0; if_addr = $urandom;
    end
    m_last_ls = own_ls;
    #1;
    chk("mem_req_valid", mem_req_valid, 1);
    chk("busy_req", busy, 1);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wen", mem_wen, e_wen);
    chk("mem_wmask", mem_wmask, e_wmask);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("resp_pulse_len", {if_resp_valid, ls_resp_valid}, 0);
    chk("ready_when_busy", {if_req_ready, ls_req_ready}, 0);
  endtask

  // stall: cycles of mem_req_ready low; dly: cycles from handshake to response (0 = same cycle).
  task automatic finish(input int stall, input int dly, input logic [31:0] rd);
    repeat (stall) begin
      mem_req_ready = 0;
      step();
      chk("hold_valid", mem_req_valid, 1);
      chk("hold_addr", mem_addr, e_addr);
      chk("hold_wdata", mem_wdata, e_wdata);
    end
    mem_req_ready = 1;
    mem_resp_valid = (dly == 0);
    mem_rdata = (dly == 0) ? rd : $urandom;
    step();
    mem_req_ready = 0;
    if (dly > 0) begin
      mem_resp_valid = 0;
      chk("wait_req_valid", mem_req_valid, 0);
      chk("wait_busy", busy, 1);
      for (int i = 1; i < dly; i++) begin
        step();
        chk("wait_no_resp", {if_resp_valid, ls_resp_valid}, 0);
      end
      mem_resp_valid = 1; mem_rdata = rd;
      step();
    end
    mem_resp_valid = 0; mem_rdata = $urandom;
    if (own_ls) m_ls_rd = rd; else m_if_rd = rd;
    chk("if_resp_valid", if_resp_valid, !own_ls);
    chk("ls_resp_valid", ls_resp_valid, own_ls);
    chk("if_rdata", if_rdata, m_if_rd);
    chk("ls_rdata", ls_rdata, m_ls_rd);
    chk("resp_err", {if_resp_err, ls_resp_err}, 0);
    chk("idle_at_resp", busy, 0);
    chk("payload_hold", mem_addr, e_addr);
  endtask

  initial begin
    if_addr = 0; ls_addr = 0; ls_wen = 0; ls_wmask = 0; ls_wdata = 0;
    model_reset();
    rst = 1'b0;
    step(); step();
    check_reset_state();
    rst = 1'b1;

    // Fetch with immediate handshake and response the next cycle.
    req_if(32'h8000_0000);
    accept();
    chk("fetch_owner", own_ls, 0);
    finish(0, 1, 32'h0000_0413);

    // Store with memory stalling the handshake three cycles.
    req_ls(32'h8000_1000, 1'b1, 4'hF, 32'hDEAD_BEEF);
    accept();
    finish(3, 2, $urandom);

    // Contention from reset: IF, LS, IF, LS.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rand_reqs(1, 1);
      accept();
      chk("grant_order", own_ls, i % 2);
      finish($urandom_range(0, 2), $urandom_range(0, 2), $urandom);
    end

    // Handshake and response in the same cycle (IF still pending from contention).
    accept();
    finish(0, 0, 32'h1234_5678);

    // Reset while waiting: the late response must be dropped.
    req_ls($urandom, 1'b0, 4'h0, 0);
    accept();
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b0;
    #1 chk("async_rst_busy", busy, 0);
    step();
    rst = 1'b1;
    model_reset();
    mem_resp_valid = 1; mem_rdata = $urandom;
    step();
    mem_resp_valid = 0;
    chk("post_rst_no_resp", {if_resp_valid, ls_resp_valid}, 0);
    chk("post_rst_busy", busy, 0);
    step();
    chk("post_rst_no_resp2", {if_resp_valid, ls_resp_valid}, 0);
    chk("post_rst_rdata", if_rdata | ls_rdata, 0);

    // Memory never answers.
    req_if($urandom);
    accept();
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
`ifdef MEM_ARB_TIMEOUT_EN
    repeat (7) step();
    chk("to_still_busy", busy, 1);
    chk("to_no_early_resp", if_resp_valid, 0);
    step();
    chk("to_resp_valid", if_resp_valid, 1);
    chk("to_resp_err", if_resp_err, 1);
    chk("to_rdata", if_rdata, 0);
    chk("to_flag", timeout_flag, 1);
    chk("to_idle", busy, 0);
    m_if_rd = 0;
    step();
    chk("to_flag_sticky", timeout_flag, 1);
    chk("to_pulse_len", if_resp_valid, 0);
`else
    repeat (120) step();
    chk("hang_busy", busy, 1);
    chk("hang_no_resp", {if_resp_valid, ls_resp_valid, timeout_flag}, 0);
    x_rd = $urandom;
    mem_resp_valid = 1; mem_rdata = x_rd;
    step();
    mem_resp_valid = 0;
    m_if_rd = x_rd;
    chk("late_resp_valid", if_resp_valid, 1);
    chk("late_rdata", if_rdata, x_rd);
    chk("late_idle", busy, 0);
`endif

    // Random traffic.
    for (int n = 0; n < 60; n++) begin
      bit w_if, w_ls;
      w_if = 1'($urandom);
      w_ls = 1'($urandom);
      if (!w_if && !w_ls && !p_if && !p_ls) w_if = 1;
      rand_reqs(w_if, w_ls);
      accept();
      finish($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
